// File: rtl/l2_bus_arbiter.sv
// Two-way L2 bus arbiter between the I-side and D-side L1 caches.
// Owns one transaction at a time, latches the request toward L2 and routes the completion back.
package l2_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 64;

    typedef struct packed {
        logic              mem_req_load;
        logic              mem_req_store;
        logic [ADDR_W-1:0] mem_addr;
        logic [LINE_W-1:0] mem_data_out;
    } mem_bus_req_t;

    typedef struct packed {
        logic              mem_ready;
        logic [LINE_W-1:0] mem_data;
    } mem_bus_resp_t;
endpackage

module l2_bus_arbiter
    import l2_bus_pkg::*;
#(
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  mem_bus_req_t  i_req,
    output mem_bus_resp_t i_resp,
    input  mem_bus_req_t  d_req,
    output mem_bus_resp_t d_resp,
    output mem_bus_req_t  l2_req,
    input  mem_bus_resp_t l2_resp,
    output logic          owner,
    output logic          busy,
    output logic          timeout_err
);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    // A limit the saturating counter can never reach leaves the watchdog off.
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0) &&
                           (longint'(TIMEOUT_CYCLES) < (longint'(1) << CNT_WIDTH));

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t               state_q, state_d;
    mem_bus_req_t         l2_req_q, l2_req_d;
    logic                 owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 i_want, d_want, winner;
    mem_bus_req_t         win_req;

    always_comb begin
        i_want = i_req.mem_req_load | i_req.mem_req_store;
        d_want = d_req.mem_req_load | d_req.mem_req_store;
        if (i_want && d_want) begin
            winner = (ARB_MODE == 1) ? OWN_D : ~last_grant_q;
        end else begin
            winner = d_want;
        end
        win_req = winner ? d_req : i_req;
    end

    always_comb begin
        state_d      = state_q;
        l2_req_d     = l2_req_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (i_want || d_want) begin
                    state_d               = ST_BUSY;
                    l2_req_d              = win_req;
                    l2_req_d.mem_req_load = win_req.mem_req_load & ~win_req.mem_req_store;
                    owner_d               = winner;
                    cnt_d                 = '0;
                end
            end
            ST_BUSY: begin
                // Requester inputs are ignored here: the transaction always runs to the ready pulse.
                if (l2_resp.mem_ready) begin
                    state_d                = ST_IDLE;
                    l2_req_d.mem_req_load  = 1'b0;
                    l2_req_d.mem_req_store = 1'b0;
                    last_grant_d           = owner_q;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    if (TO_EN && (cnt_d == TO_LIMIT)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            l2_req_q     <= '0;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            l2_req_q     <= l2_req_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        i_resp = '0;
        d_resp = '0;
        if (state_q == ST_BUSY) begin
            if (owner_q == OWN_D) begin
                d_resp = l2_resp;
            end else begin
                i_resp = l2_resp;
            end
        end
    end

    assign l2_req      = l2_req_q;
    assign owner       = owner_q;
    assign busy        = (state_q == ST_BUSY);
    assign timeout_err = timeout_q;
endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: dut0 is round-robin with an 8-cycle watchdog, dut1 is fixed-priority
// with the watchdog off; both share the same requester and L2 inputs.
module tb_l2_bus_arbiter;
    import l2_bus_pkg::*;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    mem_bus_req_t  i_req, d_req;
    mem_bus_resp_t l2_resp;
    mem_bus_resp_t i_resp0, d_resp0, i_resp1, d_resp1;
    mem_bus_req_t  l2_req0, l2_req1;
    logic          owner0, busy0, to0, owner1, busy1, to1;
    int            checks = 0;
    int            failures = 0;

    always #5 clock = ~clock;

    l2_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut0 (
        .clock(clock), .reset_n(reset_n), .i_req(i_req), .i_resp(i_resp0), .d_req(d_req),
        .d_resp(d_resp0), .l2_req(l2_req0), .l2_resp(l2_resp), .owner(owner0), .busy(busy0),
        .timeout_err(to0));

    l2_bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(0), .CNT_WIDTH(16)) dut1 (
        .clock(clock), .reset_n(reset_n), .i_req(i_req), .i_resp(i_resp1), .d_req(d_req),
        .d_resp(d_resp1), .l2_req(l2_req1), .l2_resp(l2_resp), .owner(owner1), .busy(busy1),
        .timeout_err(to1));

    function automatic mem_bus_req_t mk_req(input logic ld, input logic st,
                                            input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] dt);
        mem_bus_req_t r;
        r.mem_req_load  = ld;
        r.mem_req_store = st;
        r.mem_addr      = a;
        r.mem_data_out  = dt;
        return r;
    endfunction

    function automatic mem_bus_resp_t mk_resp(input logic rdy, input logic [LINE_W-1:0] dt);
        mem_bus_resp_t r;
        r.mem_ready = rdy;
        r.mem_data  = dt;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        i_req   = '0;
        d_req   = '0;
        l2_resp = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        i_req   = mk_req(1'b1, 1'b0, 32'h10, 64'h0);
        d_req   = mk_req(1'b0, 1'b1, 32'h20, 64'h1);
        l2_resp = mk_resp(1'b1, 64'hABCD);
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if ({busy0, owner0, to0} !== 3'b000 || l2_req0 !== '0) begin
            failures++;
            $display("FAIL reset_dut0 busy/owner/to=%b l2_req=%h required 000 and 0", {busy0, owner0, to0}, l2_req0);
        end
        checks++;
        if ({busy1, owner1, to1} !== 3'b000 || l2_req1 !== '0) begin
            failures++;
            $display("FAIL reset_dut1 busy/owner/to=%b l2_req=%h required 000 and 0", {busy1, owner1, to1}, l2_req1);
        end
        checks++;
        if (i_resp0 !== '0 || d_resp0 !== '0 || i_resp1 !== '0 || d_resp1 !== '0) begin
            failures++;
            $display("FAIL reset_resp i0=%h d0=%h i1=%h d1=%h required 0", i_resp0, d_resp0, i_resp1, d_resp1);
        end
        do_reset();
    endtask

    task automatic test_d_load();
        logic [LINE_W-1:0] line = 64'hDEAD_BEEF_0123_4567;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clock);
            i_req   = '0;
            d_req   = (c < 4) ? mk_req(1'b1, 1'b0, 32'h40, 64'h0) : '0;
            l2_resp = mk_resp(c == 4 || c == 5, (c == 4) ? line : 64'h5555);
            #1;
            if (c == 0 || c >= 5) begin
                checks++;
                if (busy0 !== 1'b0 || d_resp0 !== '0) begin
                    failures++;
                    $display("FAIL dload_idle c=%0d busy=%b d_resp=%h required 0", c, busy0, d_resp0);
                end
            end else begin
                checks++;
                if ({busy0, owner0, l2_req0.mem_req_load, l2_req0.mem_req_store} !== 4'b1110 ||
                    l2_req0.mem_addr !== 32'h40) begin
                    failures++;
                    $display("FAIL dload_busy c=%0d busy/owner/ld/st=%b addr=%h required 1110 addr 40", c,
                             {busy0, owner0, l2_req0.mem_req_load, l2_req0.mem_req_store}, l2_req0.mem_addr);
                end
                checks++;
                if (d_resp0.mem_ready !== (c == 4)) begin
                    failures++;
                    $display("FAIL dload_ready c=%0d got %b required %b", c, d_resp0.mem_ready, (c == 4));
                end
            end
            if (c == 4) begin
                checks++;
                if (d_resp0.mem_data !== line) begin
                    failures++;
                    $display("FAIL dload_data got %h required %h", d_resp0.mem_data, line);
                end
            end
            if (c >= 5) begin
                checks++;
                if (l2_req0.mem_req_load !== 1'b0 || l2_req0.mem_addr !== 32'h40) begin
                    failures++;
                    $display("FAIL dload_hold c=%0d ld=%b addr=%h required 0 and 40", c,
                             l2_req0.mem_req_load, l2_req0.mem_addr);
                end
            end
            checks++;
            if (i_resp0 !== '0) begin
                failures++;
                $display("FAIL dload_iresp c=%0d got %h required 0", c, i_resp0);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [LINE_W-1:0] dd = 64'h1111_2222_3333_4444;
        mem_bus_req_t      exp;
        logic              exp_own;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clock);
            i_req   = mk_req(1'b1, 1'b0, 32'h100, 64'h0);
            d_req   = mk_req(1'b1, 1'b1, 32'h200, dd);
            l2_resp = mk_resp(c % 2 == 1, 64'h0);
            #1;
            if (c % 2 == 1) begin
                exp_own = ((c - 1) / 2) % 2 == 1;
                exp     = exp_own ? mk_req(1'b0, 1'b1, 32'h200, dd) : mk_req(1'b1, 1'b0, 32'h100, 64'h0);
                checks++;
                if (busy0 !== 1'b1 || owner0 !== exp_own || l2_req0 !== exp) begin
                    failures++;
                    $display("FAIL rr_grant c=%0d busy=%b owner=%b l2_req=%h required 1 %b %h", c, busy0,
                             owner0, l2_req0, exp_own, exp);
                end
            end else if (c > 0) begin
                checks++;
                if (busy0 !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_gap c=%0d busy=%b required 0", c, busy0);
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [LINE_W-1:0] dd = 64'h0BAD_F00D_0000_0007;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clock);
            i_req   = mk_req(1'b0, 1'b1, 32'h180, 64'h9);
            d_req   = mk_req(1'b1, 1'b0, 32'h280, dd);
            l2_resp = mk_resp(c % 2 == 1, 64'h0);
            #1;
            if (c % 2 == 1) begin
                checks++;
                if (busy1 !== 1'b1 || owner1 !== 1'b1 || l2_req1 !== mk_req(1'b1, 1'b0, 32'h280, dd)) begin
                    failures++;
                    $display("FAIL fixed_grant c=%0d busy=%b owner=%b l2_req=%h required D load 280", c,
                             busy1, owner1, l2_req1);
                end
            end else if (c > 0) begin
                checks++;
                if (busy1 !== 1'b0) begin
                    failures++;
                    $display("FAIL fixed_gap c=%0d busy=%b required 0", c, busy1);
                end
            end
        end
    endtask

    task automatic test_owner_drop();
        logic [LINE_W-1:0] sd = 64'hCAFE_0000_1234_5678;
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clock);
            d_req   = (c < 2) ? mk_req(1'b0, 1'b1, 32'h80, sd) : mk_req(1'b0, 1'b0, 32'hFC0, 64'h1);
            i_req   = (c >= 2) ? mk_req(1'b1, 1'b0, 32'h500, 64'h0) : '0;
            l2_resp = mk_resp(c == 5, 64'h77);
            #1;
            if (c >= 1 && c <= 5) begin
                checks++;
                if (busy0 !== 1'b1 || owner0 !== 1'b1 || l2_req0 !== mk_req(1'b0, 1'b1, 32'h80, sd)) begin
                    failures++;
                    $display("FAIL drop_hold c=%0d busy=%b owner=%b l2_req=%h required D store 80", c,
                             busy0, owner0, l2_req0);
                end
                checks++;
                if (d_resp0.mem_ready !== (c == 5) || i_resp0 !== '0) begin
                    failures++;
                    $display("FAIL drop_resp c=%0d d_rdy=%b i_resp=%h required %b and 0", c,
                             d_resp0.mem_ready, i_resp0, (c == 5));
                end
            end
            if (c == 6) begin
                checks++;
                if (busy0 !== 1'b0) begin
                    failures++;
                    $display("FAIL drop_idle busy=%b required 0", busy0);
                end
            end
            if (c == 7) begin
                checks++;
                if (busy0 !== 1'b1 || owner0 !== 1'b0 || l2_req0 !== mk_req(1'b1, 1'b0, 32'h500, 64'h0)) begin
                    failures++;
                    $display("FAIL drop_next busy=%b owner=%b l2_req=%h required I load 500", busy0, owner0,
                             l2_req0);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            @(negedge clock);
            i_req   = (c == 0) ? mk_req(1'b1, 1'b0, 32'h300, 64'h0) : '0;
            d_req   = '0;
            l2_resp = mk_resp(c == 21, 64'h0);
            #1;
            if (c >= 1) begin
                checks++;
                if (busy0 !== (c <= 21) || to0 !== (c >= 9)) begin
                    failures++;
                    $display("FAIL timeout c=%0d busy=%b to=%b required %b %b", c, busy0, to0, (c <= 21),
                             (c >= 9));
                end
                checks++;
                if (to1 !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_off c=%0d to=%b required 0", c, to1);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clock);
        d_req   = mk_req(1'b1, 1'b0, 32'h40, 64'h0);
        i_req   = mk_req(1'b0, 1'b1, 32'h44, 64'h2);
        l2_resp = '0;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre busy0=%b busy1=%b required 1 1", busy0, busy1);
        end
        #2;
        l2_resp = mk_resp(1'b1, 64'hFFFF);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy0, l2_req0.mem_req_load, l2_req0.mem_req_store, i_resp0.mem_ready, d_resp0.mem_ready,
             busy1, l2_req1.mem_req_load, l2_req1.mem_req_store, i_resp1.mem_ready, d_resp1.mem_ready} !== 10'b0) begin
            failures++;
            $display("FAIL areset_now dut0 busy=%b ld/st=%b%b dut1 busy=%b ld/st=%b%b required all 0", busy0,
                     l2_req0.mem_req_load, l2_req0.mem_req_store, busy1, l2_req1.mem_req_load,
                     l2_req1.mem_req_store);
        end
        @(negedge clock);
        i_req   = mk_req(1'b1, 1'b0, 32'h600, 64'h0);
        d_req   = mk_req(1'b1, 1'b0, 32'h700, 64'h0);
        l2_resp = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (busy0 !== 1'b1 || owner0 !== 1'b0 || l2_req0.mem_addr !== 32'h600) begin
            failures++;
            $display("FAIL areset_first busy=%b owner=%b addr=%h required 1 0 600", busy0, owner0,
                     l2_req0.mem_addr);
        end
        checks++;
        if (busy1 !== 1'b1 || owner1 !== 1'b1) begin
            failures++;
            $display("FAIL areset_fixed busy=%b owner=%b required 1 1", busy1, owner1);
        end
    endtask

    task automatic test_random();
        logic          m_busy [2];
        logic          m_owner[2];
        logic          m_last [2];
        logic          m_to   [2];
        int            m_wait [2];
        mem_bus_req_t  m_req  [2];
        int            mode   [2];
        int            limit  [2];
        mem_bus_req_t  l2, req;
        mem_bus_resp_t ir, dr, exp_i, exp_d;
        logic          b, o, t, wi, wd;
        int            who;
        mode  = '{0, 1};
        limit = '{8, 0};
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_owner[k] = 1'b0; m_last[k] = 1'b1; m_to[k] = 1'b0;
            m_wait[k] = 0; m_req[k] = '0;
        end
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            i_req   = mk_req(($urandom % 4) == 0, ($urandom % 4) == 0, $urandom, {$urandom, $urandom});
            d_req   = mk_req(($urandom % 4) == 0, ($urandom % 4) == 0, $urandom, {$urandom, $urandom});
            l2_resp = mk_resp(($urandom % 3) == 0, {$urandom, $urandom});
            #1;
            for (int k = 0; k < 2; k++) begin
                b  = k ? busy1 : busy0;
                o  = k ? owner1 : owner0;
                t  = k ? to1 : to0;
                l2 = k ? l2_req1 : l2_req0;
                ir = k ? i_resp1 : i_resp0;
                dr = k ? d_resp1 : d_resp0;
                exp_i = (m_busy[k] && !m_owner[k]) ? l2_resp : '0;
                exp_d = (m_busy[k] && m_owner[k]) ? l2_resp : '0;
                checks++;
                if ({b, o, t} !== {m_busy[k], m_owner[k], m_to[k]}) begin
                    failures++;
                    $display("FAIL rand_ctrl dut%0d n=%0d busy/owner/to=%b required %b", k, n, {b, o, t},
                             {m_busy[k], m_owner[k], m_to[k]});
                end
                checks++;
                if (l2 !== m_req[k]) begin
                    failures++;
                    $display("FAIL rand_l2req dut%0d n=%0d got %h required %h", k, n, l2, m_req[k]);
                end
                checks++;
                if (ir !== exp_i || dr !== exp_d) begin
                    failures++;
                    $display("FAIL rand_resp dut%0d n=%0d i=%h d=%h required %h %h", k, n, ir, dr, exp_i, exp_d);
                end
            end
            @(posedge clock);
            for (int k = 0; k < 2; k++) begin
                wi = i_req.mem_req_load | i_req.mem_req_store;
                wd = d_req.mem_req_load | d_req.mem_req_store;
                if (!m_busy[k]) begin
                    if (wi || wd) begin
                        if (wi && wd) who = (mode[k] == 1) ? 1 : (m_last[k] ? 0 : 1);
                        else          who = wd ? 1 : 0;
                        req = (who == 1) ? d_req : i_req;
                        if (req.mem_req_store) req.mem_req_load = 1'b0;
                        m_req[k]   = req;
                        m_owner[k] = (who == 1);
                        m_busy[k]  = 1'b1;
                        m_wait[k]  = 0;
                    end
                end else if (l2_resp.mem_ready) begin
                    m_busy[k] = 1'b0;
                    m_req[k].mem_req_load  = 1'b0;
                    m_req[k].mem_req_store = 1'b0;
                    m_last[k] = m_owner[k];
                end else begin
                    m_wait[k]++;
                    if (limit[k] != 0 && m_wait[k] >= limit[k]) m_to[k] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_d_load();
        test_round_robin();
        test_fixed_priority();
        test_owner_drop();
        test_timeout();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
